// File: rtl/ne_fp_ffp_acc_m33.sv
// ne_fp_ffp_acc_m33 -- ffp dot-product accumulator.
//
// Sums a stream of 47-bit ffp terms into one ffp bundle per group. A group
// ends with the term carrying in_last. Results use the input layout of the
// downstream ffp-to-fp32 converter, which also performs normalization.
// Float modes (tf32/fp8) use exponent-aligned signed-mantissa addition.
// int8 mode uses a saturating signed 22-bit sum.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   mode       4'b0100 tf32, 4'b0010 fp8, 4'b0001 int8; latched on first term
//   in_valid   input term valid
//   in_ready   input term accepted when in_valid & in_ready
//   in_data    term: [46] nan, [45] inf, [44] zero, [43:34] e, [33] s, [32:0] m
//   in_last    final term of the group
//   out_valid  result valid; held with out_data/out_mode until out_ready
//   out_ready  result consumed when out_valid & out_ready
//   out_data   result bundle, same layout as in_data
//   out_mode   mode of the group
//   exc_cnt    saturating count of inf/nan results
//
// Optional feature: define NE_FFP_ACC_EXC_CNT_EN to build the exception
// counter. When undefined, exc_cnt is tied to zero.
module ne_fp_ffp_acc_m33 #(
    parameter int INTWI = 22,
    parameter int STWI  = 3,
    parameter int EWI   = 10,
    parameter int SWI   = 1,
    parameter int SMWI  = 33,
    parameter int DATAW = STWI + EWI + SWI + SMWI
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic [3:0]       out_mode,
    output logic [15:0]      exc_cnt
);

    localparam int                     E_LSB     = SWI + SMWI;
    localparam logic [3:0]             MODE_INT8 = 4'b0001;
    localparam logic signed [EWI:0]    E_MAX     = {2'b00, {(EWI-1){1'b1}}};
    localparam logic [EWI:0]           SH_SAT    = (EWI+1)'(SMWI + 1);
    localparam logic [INTWI-1:0]       INT_MAX   = {1'b0, {(INTWI-1){1'b1}}};
    localparam logic [INTWI-1:0]       INT_MIN   = {1'b1, {(INTWI-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Arithmetic shift right; shifts past the full width give pure sign fill.
    function automatic logic [SMWI:0] asr_f(input logic [SMWI:0] v, input logic [EWI:0] sh);
        logic [SMWI:0] r;
        if (sh >= SH_SAT) begin
            r = {(SMWI+1){v[SMWI]}};
        end else begin
            r = $unsigned($signed(v) >>> sh);
        end
        return r;
    endfunction

    // Build the output bundle from accumulator contents.
    function automatic logic [DATAW-1:0] pack_f(input logic is_int, input logic nan,
                                                input logic inf, input logic isgn,
                                                input logic [EWI-1:0] e,
                                                input logic [SMWI-1:0] m,
                                                input logic [INTWI-1:0] iv);
        logic [DATAW-1:0] r;
        r = {DATAW{1'b0}};
        if (is_int) begin
            r[INTWI-1:0] = iv;
        end else if (nan) begin
            r[DATAW-1] = 1'b1;
            r[SMWI]    = isgn;
        end else if (inf) begin
            r[DATAW-2] = 1'b1;
            r[SMWI]    = isgn;
        end else begin
            r[DATAW-3]         = (m == {SMWI{1'b0}});
            r[E_LSB +: EWI]    = e;
            r[SMWI]            = m[SMWI-1];
            r[SMWI-1:0]        = m;
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_nx_s;

    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [DATAW-1:0]     out_data_r;
    logic [3:0]           out_mode_r;

    logic [3:0]           mode_r;
    logic                 acc_nan_r;
    logic                 acc_inf_r;
    logic                 acc_isgn_r;
    logic [EWI-1:0]       acc_e_r;
    logic [SMWI-1:0]      acc_m_r;
    logic [INTWI-1:0]     acc_int_r;

    logic                 accept_s;
    logic                 last_acc_s;
    logic                 done_s;

    // Term fields; m[32] duplicates the sign and is not needed.
    logic                 t_nan_s;
    logic                 t_inf_s;
    logic                 t_zero_s;
    logic [EWI-1:0]       t_e_s;
    logic                 t_sgn_s;
    logic [SMWI-1:0]      t_m_s;
    logic [INTWI-1:0]     t_int_s;
    logic                 unused_m_top_s;

    logic signed [EWI:0]  d_s;
    logic [EWI:0]         nd_s;
    logic signed [EWI:0]  e_res_s;
    logic signed [EWI:0]  e_sum_s;
    logic [SMWI:0]        a_s;
    logic [SMWI:0]        b_s;
    logic [SMWI:0]        sum_s;
    logic [SMWI-1:0]      sum_m_s;
    logic                 e_big_s;

    logic                 add_nan_s;
    logic                 add_inf_s;
    logic                 add_isgn_s;
    logic [EWI-1:0]       add_e_s;
    logic [SMWI-1:0]      add_m_s;
    logic [INTWI:0]       int_sum_s;
    logic [INTWI-1:0]     int_add_s;

    logic                 nx_nan_s;
    logic                 nx_inf_s;
    logic                 nx_isgn_s;
    logic [EWI-1:0]       nx_e_s;
    logic [SMWI-1:0]      nx_m_s;
    logic [INTWI-1:0]     nx_int_s;
    logic [3:0]           nx_mode_s;

    assign accept_s       = in_valid & in_ready_r;
    assign last_acc_s     = accept_s & in_last;
    assign done_s         = out_valid_r & out_ready;

    assign t_nan_s        = in_data[DATAW-1];
    assign t_inf_s        = in_data[DATAW-2];
    assign t_zero_s       = in_data[DATAW-3];
    assign t_e_s          = in_data[E_LSB +: EWI];
    assign t_sgn_s        = in_data[SMWI];
    assign t_m_s          = {t_sgn_s, in_data[SMWI-2:0]};
    assign t_int_s        = in_data[INTWI-1:0];
    assign unused_m_top_s = in_data[SMWI-1];

    // Next-state logic of the group FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = in_last ? HOLD : ACC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACC: begin
                if (last_acc_s) begin
                    state_nx_s = HOLD;
                end else begin
                    state_nx_s = ACC;
                end
            end
            HOLD: begin
                if (done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Exponent alignment, 34-bit mantissa sum and one-step overflow renormalization.
    always_comb begin
        d_s  = $signed({t_e_s[EWI-1], t_e_s}) - $signed({acc_e_r[EWI-1], acc_e_r});
        nd_s = {(EWI+1){1'b0}} - d_s;
        if (!d_s[EWI]) begin
            a_s     = asr_f({acc_m_r[SMWI-1], acc_m_r}, d_s);
            b_s     = {t_m_s[SMWI-1], t_m_s};
            e_res_s = $signed({t_e_s[EWI-1], t_e_s});
        end else begin
            a_s     = {acc_m_r[SMWI-1], acc_m_r};
            b_s     = asr_f({t_m_s[SMWI-1], t_m_s}, nd_s);
            e_res_s = $signed({acc_e_r[EWI-1], acc_e_r});
        end
        sum_s = a_s + b_s;
        // Top two bits disagree: the sum does not fit in 33 signed bits.
        if (sum_s[SMWI] ^ sum_s[SMWI-1]) begin
            sum_m_s = sum_s[SMWI:1];
            e_sum_s = e_res_s + 11'sd1;
        end else begin
            sum_m_s = sum_s[SMWI-1:0];
            e_sum_s = e_res_s;
        end
        e_big_s = (e_sum_s > E_MAX);
    end

    // Float accumulate of one non-first term, including sticky specials.
    always_comb begin
        add_nan_s  = acc_nan_r;
        add_inf_s  = acc_inf_r;
        add_isgn_s = acc_isgn_r;
        add_e_s    = acc_e_r;
        add_m_s    = acc_m_r;
        if (t_nan_s) begin
            add_nan_s = 1'b1;
        end else if (t_inf_s) begin
            if (acc_inf_r && (acc_isgn_r != t_sgn_s)) begin
                add_nan_s = 1'b1;
            end else begin
                add_inf_s  = 1'b1;
                add_isgn_s = t_sgn_s;
            end
        end else if (t_zero_s) begin
            add_m_s = acc_m_r;
        end else if (acc_m_r == {SMWI{1'b0}}) begin
            add_e_s = t_e_s;
            add_m_s = t_m_s;
        end else begin
            add_e_s = e_sum_s[EWI-1:0];
            add_m_s = sum_m_s;
            if (e_big_s) begin
                if (acc_inf_r && (acc_isgn_r != sum_s[SMWI])) begin
                    add_nan_s = 1'b1;
                end else begin
                    add_inf_s  = 1'b1;
                    add_isgn_s = sum_s[SMWI];
                end
            end else begin
                add_inf_s = acc_inf_r;
            end
        end
    end

    // Saturating int8-mode sum.
    always_comb begin
        int_sum_s = {acc_int_r[INTWI-1], acc_int_r} + {t_int_s[INTWI-1], t_int_s};
        if (int_sum_s[INTWI] ^ int_sum_s[INTWI-1]) begin
            int_add_s = int_sum_s[INTWI] ? INT_MIN : INT_MAX;
        end else begin
            int_add_s = int_sum_s[INTWI-1:0];
        end
    end

    // First term of a group is loaded as-is; later terms go through the adders.
    always_comb begin
        if (state_r == IDLE) begin
            nx_nan_s  = t_nan_s;
            nx_inf_s  = t_inf_s;
            nx_isgn_s = t_inf_s & t_sgn_s;
            nx_e_s    = t_e_s;
            nx_m_s    = t_zero_s ? {SMWI{1'b0}} : t_m_s;
            nx_int_s  = t_int_s;
            nx_mode_s = mode;
        end else begin
            nx_nan_s  = add_nan_s;
            nx_inf_s  = add_inf_s;
            nx_isgn_s = add_isgn_s;
            nx_e_s    = add_e_s;
            nx_m_s    = add_m_s;
            nx_int_s  = int_add_s;
            nx_mode_s = mode_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Accumulator registers, updated on every accepted term.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r     <= 4'd0;
            acc_nan_r  <= 1'b0;
            acc_inf_r  <= 1'b0;
            acc_isgn_r <= 1'b0;
            acc_e_r    <= {EWI{1'b0}};
            acc_m_r    <= {SMWI{1'b0}};
            acc_int_r  <= {INTWI{1'b0}};
        end else if (accept_s) begin
            mode_r     <= nx_mode_s;
            acc_nan_r  <= nx_nan_s;
            acc_inf_r  <= nx_inf_s;
            acc_isgn_r <= nx_isgn_s;
            acc_e_r    <= nx_e_s;
            acc_m_r    <= nx_m_s;
            acc_int_r  <= nx_int_s;
        end
    end

    // Output registers: result captured with the last term, held until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATAW{1'b0}};
            out_mode_r  <= 4'd0;
        end else if (last_acc_s) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= pack_f(nx_mode_s == MODE_INT8, nx_nan_s, nx_inf_s & ~nx_nan_s,
                                  nx_isgn_s, nx_e_s, nx_m_s, nx_int_s);
            out_mode_r  <= nx_mode_s;
        end else if (done_s) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end
    end

`ifdef NE_FFP_ACC_EXC_CNT_EN
    logic [15:0] exc_cnt_r;

    // Count consumed inf/nan results, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_cnt_r <= 16'd0;
        end else if (done_s && (out_data_r[DATAW-1] | out_data_r[DATAW-2])
                     && (exc_cnt_r != 16'hFFFF)) begin
            exc_cnt_r <= exc_cnt_r + 16'd1;
        end
    end

    assign exc_cnt = exc_cnt_r;
`else
    assign exc_cnt = 16'd0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_mode  = out_mode_r;

endmodule

// File: tb/tb_ne_fp_ffp_acc_m33.sv
module tb_ne_fp_ffp_acc_m33;

    localparam logic [3:0] TF32 = 4'b0100;
    localparam logic [3:0] FP8  = 4'b0010;
    localparam logic [3:0] INT8 = 4'b0001;
    localparam longint     ONE  = 64'sh8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [46:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [46:0] out_data;
    logic [3:0]  out_mode;
    logic [15:0] exc_cnt;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_exc    = 16'd0;
    logic [46:0] terms_q[$];
    logic [3:0]  modes_q[$];

    always #5 clk = ~clk;

    ne_fp_ffp_acc_m33 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .exc_cnt   (exc_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sext33(input logic [32:0] v);
        return longint'({{31{v[32]}}, v});
    endfunction

    function automatic int sext10(input logic [9:0] v);
        return int'({{22{v[9]}}, v});
    endfunction

    function automatic longint sext22(input logic [21:0] v);
        return longint'({{42{v[21]}}, v});
    endfunction

    function automatic longint asr(input longint v, input int sh);
        if (sh >= 34) return (v < 0) ? -64'sd1 : 64'sd0;
        return v >>> sh;
    endfunction

    function automatic logic [46:0] mk_term(input bit nan, input bit inf, input bit zero,
                                            input int e, input longint mv);
        logic [9:0]  e10;
        logic [32:0] m33;
        e10 = e[9:0];
        m33 = mv[32:0];
        return {nan, inf, zero, e10, m33[32], m33};
    endfunction

    function automatic logic [3:0] pick_mode();
        case ($urandom_range(2))
            0:       return TF32;
            1:       return FP8;
            default: return INT8;
        endcase
    endfunction

    function automatic logic [46:0] rand_float_term();
        logic [32:0] r;
        int          e;
        e = int'($urandom_range(80)) - 40;
        if ($urandom_range(7) == 0) return mk_term(1'b0, 1'b0, 1'b1, e, 64'sd0);
        r = {1'($urandom_range(1)), $urandom()};
        return mk_term(1'b0, 1'b0, 1'b0, e, sext33(r));
    endfunction

    // Reference: value = M * 2^(e-31), summed with the alignment/truncation rules.
    function automatic logic [46:0] model_float();
        bit          nan, inf, isgn, ts;
        int          e, te, d;
        longint      m, tm, a, b, sum;
        logic [46:0] t;
        logic [32:0] m33;
        logic [9:0]  e10;
        t    = terms_q[0];
        nan  = t[46];
        inf  = t[45];
        isgn = t[45] & t[33];
        e    = sext10(t[43:34]);
        m    = t[44] ? 64'sd0 : sext33({t[33], t[31:0]});
        for (int i = 1; i < terms_q.size(); i++) begin
            t  = terms_q[i];
            ts = t[33];
            te = sext10(t[43:34]);
            tm = sext33({t[33], t[31:0]});
            if (t[46]) begin
                nan = 1'b1;
            end else if (t[45]) begin
                if (inf && isgn != ts) nan = 1'b1;
                else begin inf = 1'b1; isgn = ts; end
            end else if (t[44]) begin
            end else if (m == 0) begin
                e = te;
                m = tm;
            end else begin
                d = te - e;
                if (d >= 0) begin a = asr(m, d); b = tm; e = te; end
                else begin a = m; b = asr(tm, -d); end
                sum = a + b;
                if (sum > 64'sd4294967295 || sum < -64'sd4294967296) begin
                    sum = sum >>> 1;
                    e   = e + 1;
                end
                m = sum;
                if (e > 511) begin
                    if (inf && isgn != (sum < 0)) nan = 1'b1;
                    else begin inf = 1'b1; isgn = (sum < 0); end
                end
            end
        end
        if (nan) return {3'b100, 10'd0, isgn, 33'd0};
        if (inf) return {3'b010, 10'd0, isgn, 33'd0};
        m33 = m[32:0];
        e10 = e[9:0];
        return {2'b00, (m == 0), e10, m33[32], m33};
    endfunction

    function automatic logic [46:0] model_int();
        longint     s;
        logic [21:0] s22;
        s = 0;
        for (int i = 0; i < terms_q.size(); i++) begin
            s = s + sext22(terms_q[i][21:0]);
            if (s > 64'sd2097151)  s = 64'sd2097151;
            if (s < -64'sd2097152) s = -64'sd2097152;
        end
        s22 = s[21:0];
        return {25'd0, s22};
    endfunction

    task automatic add_term(input logic [46:0] t, input logic [3:0] m);
        terms_q.push_back(t);
        modes_q.push_back(m);
    endtask

    task automatic check_reset(input string tag);
        chk($sformatf("%s:in_ready", tag),  in_ready,  1);
        chk($sformatf("%s:out_valid", tag), out_valid, 0);
        chk($sformatf("%s:out_data", tag),  out_data,  0);
        chk($sformatf("%s:out_mode", tag),  out_mode,  0);
        chk($sformatf("%s:exc_cnt", tag),   exc_cnt,   0);
    endtask

    // Drive the queued group, hold the result for 'hold' cycles, then consume it.
    task automatic send_group(input string tag, input int hold,
                              input bit use_want, input logic [46:0] want);
        logic [46:0] exp;
        logic [3:0]  expm;
        int          n;
        n    = terms_q.size();
        expm = modes_q[0];
        exp  = (expm == INT8) ? model_int() : model_float();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s:in_ready", tag), in_ready, 1);
            chk($sformatf("%s:early_valid", tag), out_valid, 0);
            in_valid = 1'b1;
            in_data  = terms_q[i];
            mode     = modes_q[i];
            in_last  = (i == n - 1);
        end
        @(negedge clk);
        in_valid = (hold > 0);
        in_data  = {3'b100, $urandom(), 12'hABC};
        in_last  = 1'b1;
        mode     = pick_mode();
        chk($sformatf("%s:out_valid", tag), out_valid, 1);
        chk($sformatf("%s:out_data", tag), out_data, exp);
        chk($sformatf("%s:out_mode", tag), out_mode, expm);
        if (use_want) chk($sformatf("%s:out_data_const", tag), out_data, want);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk($sformatf("%s:hold_valid", tag), out_valid, 1);
            chk($sformatf("%s:hold_data", tag), out_data, exp);
            chk($sformatf("%s:hold_ready", tag), in_ready, 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef NE_FFP_ACC_EXC_CNT_EN
        if (exp[46] | exp[45]) exp_exc = exp_exc + 16'd1;
`endif
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s:valid_drop", tag), out_valid, 0);
        chk($sformatf("%s:ready_back", tag), in_ready, 1);
        chk($sformatf("%s:exc_cnt", tag), exc_cnt, exp_exc);
        terms_q.delete();
        modes_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 4'd0;
        in_valid  = 1'b0;
        in_data   = 47'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Single-term group passes through unchanged.
        add_term(mk_term(0, 0, 0, 0, 64'sh4000_0000), TF32);
        send_group("single", 0, 1'b1, {3'b000, 10'd0, 1'b0, 33'h0_4000_0000});

        // 1.0 + 1.0 overflows and renormalizes to e=1.
        add_term(mk_term(0, 0, 0, 0, ONE), TF32);
        add_term(mk_term(0, 0, 0, 0, ONE), FP8);
        send_group("renorm", 0, 1'b1, {3'b000, 10'd1, 1'b0, 33'h0_8000_0000});

        // 8.0 + 1.0 aligns the smaller term.
        add_term(mk_term(0, 0, 0, 3, ONE), FP8);
        add_term(mk_term(0, 0, 0, 0, ONE), INT8);
        send_group("align", 0, 1'b1, {3'b000, 10'd3, 1'b0, 33'h0_9000_0000});

        // +1.0 - 1.0 cancels to zero.
        add_term(mk_term(0, 0, 0, 0, ONE), TF32);
        add_term(mk_term(0, 0, 0, 0, -ONE), TF32);
        send_group("cancel", 0, 1'b1, {3'b001, 10'd0, 1'b0, 33'd0});

        // Zero-flagged term leaves accumulator untouched.
        add_term(mk_term(0, 0, 0, 0, ONE), TF32);
        add_term(mk_term(0, 0, 1, 5, 64'sd0), TF32);
        send_group("zero_term", 0, 1'b1, {3'b000, 10'd0, 1'b0, 33'h0_8000_0000});

        // +inf then -inf gives nan and counts an exception.
        add_term(mk_term(0, 1, 0, 0, 64'sd0), TF32);
        add_term(mk_term(0, 1, 0, 0, -ONE), TF32);
        send_group("inf_nan", 0, 1'b1, {3'b100, 10'd0, 1'b0, 33'd0});

        // Exponent overflow at e=511 becomes +inf.
        add_term(mk_term(0, 0, 0, 511, ONE), FP8);
        add_term(mk_term(0, 0, 0, 511, ONE), FP8);
        send_group("exp_ovf", 0, 1'b1, {3'b010, 10'd0, 1'b0, 33'd0});

        // -1.0 + -1.0 at e=511 still fits 33 bits: no inf.
        add_term(mk_term(0, 0, 0, 511, -ONE), FP8);
        add_term(mk_term(0, 0, 0, 511, -ONE), FP8);
        send_group("neg_fit", 0, 1'b1, {3'b000, 10'h1FF, 1'b1, 33'h1_0000_0000});

        // int8 saturation both ways.
        add_term({25'd0, 22'h1FFFFF}, INT8);
        add_term({25'd0, 22'h000001}, TF32);
        send_group("int_satp", 0, 1'b1, {25'd0, 22'h1FFFFF});
        add_term({25'd0, 22'h200000}, INT8);
        add_term({25'd0, 22'h3FFFFF}, INT8);
        send_group("int_satn", 0, 1'b1, {25'd0, 22'h200000});

        // Backpressure: result held for 5 cycles.
        for (int i = 0; i < 3; i++) add_term(rand_float_term(), (i == 0) ? TF32 : pick_mode());
        send_group("backpr", 5, 1'b0, 47'd0);

        // Random float and int groups; non-first modes are random.
        for (int g = 0; g < 20; g++) begin
            int n;
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++)
                add_term(rand_float_term(), (i == 0) ? ((g % 2 == 0) ? TF32 : FP8) : pick_mode());
            send_group($sformatf("rnd_f%0d", g), int'($urandom_range(2)), 1'b0, 47'd0);
        end
        for (int g = 0; g < 8; g++) begin
            int n;
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++)
                add_term({25'd0, 22'($urandom())}, (i == 0) ? INT8 : pick_mode());
            send_group($sformatf("rnd_i%0d", g), 0, 1'b0, 47'd0);
        end

        // Reset mid-group discards the partial sum.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = mk_term(0, 0, 0, 2, ONE);
        mode     = TF32;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_exc = 16'd0;
        check_reset("rst_mid");
        add_term(mk_term(0, 0, 0, 0, ONE), FP8);
        send_group("after_rst", 0, 1'b1, {3'b000, 10'd0, 1'b0, 33'h0_8000_0000});

        // Inf result then reset during HOLD.
        add_term(mk_term(0, 1, 0, 0, -ONE), TF32);
        send_group("inf_cnt", 0, 1'b1, {3'b010, 10'd0, 1'b1, 33'd0});
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = mk_term(1, 0, 0, 0, 64'sd0);
        mode     = FP8;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("rst_hold:valid", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("rst_hold");
        rst_n   = 1'b1;
        exp_exc = 16'd0;
        @(negedge clk);
        chk("rst_hold:still_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
